// File: rtl/intr_ctrl.sv
// Interrupt controller: syncs NUM_SRC request lines, latches edges as pending,
// raises intr for the lowest-index enabled pending source until ack, then waits for eoi.
// Ports: clk, reset (async active-low), irq_in, cfg_we/cfg_addr/cfg_wdata/cfg_rdata,
//        intr/intr_id/intr_vec to the core, intr_ack/eoi from the core.
module intr_ctrl #(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               intr,
  output logic [2:0]         intr_id,
  output logic [31:0]        intr_vec,
  input  logic               intr_ack,
  input  logic               eoi
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] s1, s2, prev;
  logic [NUM_SRC-1:0] pending, enable;
  logic               gie;

  logic [NUM_SRC-1:0] edge_det, cand;
  logic [NUM_SRC-1:0] ack_clr, w1c;
  logic [2:0]         pick;
  logic               has_cand;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:NUM_SRC];

  assign edge_det = s2 & ~prev;
  assign cand     = pending & enable;
  assign has_cand = |cand;

  always_comb begin
    pick = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (cand[i]) pick = 3'(i);
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++)
      ack_clr[i] = (state == REQ) && intr_ack
                   && (intr_id == 3'(i));
  end

  assign w1c = (cfg_we && cfg_addr == 2'd1)
             ? cfg_wdata[NUM_SRC-1:0] : '0;

  // a fresh edge wins over any clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      pending <= '0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      prev    <= s2;
      pending <= (pending & ~(ack_clr | w1c)) | edge_det;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable <= '0;
      gie    <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_addr == 2'd0) enable <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_addr == 2'd3) gie    <= cfg_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      intr    <= 1'b0;
      intr_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gie && has_cand) begin
            intr_id <= pick;
            intr    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (intr_ack) begin
            intr  <= 1'b0;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          intr  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign intr_vec = VEC_BASE + 32'(intr_id) * VEC_STRIDE;

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0: cfg_rdata[NUM_SRC-1:0] = enable;
      2'd1: cfg_rdata[NUM_SRC-1:0] = pending;
      2'd2: begin
        cfg_rdata[9:8] = state;
        cfg_rdata[2:0] = intr_id;
      end
      default: cfg_rdata[0] = gie;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed stimulus pushes expectations,
// monitors compare register/level samples and every new interrupt request.
module tb_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        intr;
  logic [2:0]  intr_id;
  logic [31:0] intr_vec;
  logic        intr_ack = 1'b0;
  logic        eoi = 1'b0;

  intr_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .intr     (intr),
    .intr_id  (intr_id),
    .intr_vec (intr_vec),
    .intr_ack (intr_ack),
    .eoi      (eoi)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } chk_t;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] vec;
  } irq_t;

  chk_t exp_q[$];
  irq_t irq_q[$];
  logic strobe = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  // level/register monitor
  initial begin
    chk_t        e;
    logic [31:0] act;
    logic        intr_d;
    irq_t        r;
    intr_d = 1'b0;
    forever begin
      @(negedge clk);
      if (strobe) begin
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          case (e.kind)
            0:       act = cfg_rdata;
            1:       act = {31'b0, intr};
            2:       act = {29'b0, intr_id};
            default: act = intr_vec;
          endcase
          compared++;
          if (act !== e.val) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", e.name, act, e.val);
          end
        end
      end
      if (intr && !intr_d) begin
        compared++;
        if (irq_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_intr: got id %0d want none", intr_id);
        end else begin
          r = irq_q.pop_front();
          if (intr_id !== r.id || intr_vec !== r.vec) begin
            mismatched++;
            $display("FAIL intr_event: got id %0d vec %h want id %0d vec %h",
                     intr_id, intr_vec, r.id, r.vec);
          end
        end
      end
      intr_d = intr;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    strobe = 1'b1;
    @(negedge clk);
    #1 strobe = 1'b0;
  endtask

  task automatic chk(string n, int k, logic [31:0] v);
    exp_q.push_back('{n, k, v});
  endtask

  task automatic rd(logic [1:0] a, string n, logic [31:0] v);
    cfg_addr = a;
    chk(n, 0, v);
    sample();
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic exp_irq(logic [2:0] id, logic [31:0] vec);
    irq_q.push_back('{id, vec});
  endtask

  task automatic pulse_ack();
    intr_ack = 1'b1;
    tick(1);
    intr_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  initial begin
    // reset state
    tick(3);
    rd(2'd0, "rst_enable", 32'h0);
    rd(2'd1, "rst_pending", 32'h0);
    rd(2'd2, "rst_status", 32'h0);
    rd(2'd3, "rst_gie", 32'h0);
    chk("rst_intr", 1, 32'h0);
    sample();
    tick(1);
    reset = 1'b1;

    // single source, 4-edge latency
    wr(2'd0, 32'h5);
    wr(2'd3, 32'h1);
    irq_in[2] = 1'b1;
    exp_irq(3'd2, 32'h1C0);
    tick(3);
    chk("t1_intr_edge3", 1, 32'h0);
    sample();
    tick(1);
    chk("t1_intr_edge4", 1, 32'h1);
    chk("t1_id", 2, 32'h2);
    chk("t1_vec", 3, 32'h1C0);
    sample();
    rd(2'd2, "t1_status_req", 32'h102);
    irq_in[2] = 1'b0;
    pulse_ack();
    chk("t1_intr_svc", 1, 32'h0);
    sample();
    rd(2'd1, "t1_pend_svc", 32'h0);
    rd(2'd2, "t1_status_svc", 32'h202);
    pulse_eoi();
    rd(2'd2, "t1_status_idle", 32'h002);

    // priority between two simultaneous sources
    wr(2'd0, 32'hA);
    irq_in[1] = 1'b1;
    irq_in[3] = 1'b1;
    exp_irq(3'd1, 32'h1A0);
    exp_irq(3'd3, 32'h1E0);
    tick(4);
    chk("t2_id1", 2, 32'h1);
    sample();
    rd(2'd1, "t2_pend_req", 32'hA);
    irq_in[1] = 1'b0;
    irq_in[3] = 1'b0;
    pulse_ack();
    rd(2'd1, "t2_pend_ack", 32'h8);
    pulse_eoi();
    tick(1);
    chk("t2_intr_next", 1, 32'h1);
    chk("t2_id3", 2, 32'h3);
    chk("t2_vec3", 3, 32'h1E0);
    sample();

    // masking during REQ does not withdraw
    wr(2'd0, 32'h0);
    tick(2);
    chk("t3_intr_masked", 1, 32'h1);
    chk("t3_id_masked", 2, 32'h3);
    sample();
    pulse_ack();
    rd(2'd1, "t3_pend_ack", 32'h0);
    chk("t3_intr_ack", 1, 32'h0);
    sample();
    pulse_eoi();

    // double edge in SERVICE collapses to one pending
    wr(2'd0, 32'h5);
    irq_in[2] = 1'b1;
    exp_irq(3'd2, 32'h1C0);
    tick(4);
    irq_in[2] = 1'b0;
    pulse_ack();
    for (int k = 0; k < 2; k++) begin
      irq_in[0] = 1'b1;
      tick(3);
      irq_in[0] = 1'b0;
      tick(3);
    end
    rd(2'd1, "t4_pend_svc", 32'h1);
    chk("t4_intr_svc", 1, 32'h0);
    sample();
    rd(2'd2, "t4_status_svc", 32'h202);
    exp_irq(3'd0, 32'h180);
    pulse_eoi();
    tick(1);
    chk("t4_intr_after_eoi", 1, 32'h1);
    chk("t4_id0", 2, 32'h0);
    sample();
    pulse_ack();
    rd(2'd1, "t4_pend_once", 32'h0);
    pulse_eoi();
    tick(1);
    chk("t4_no_second", 1, 32'h0);
    sample();

    // edge coinciding with ack clear
    irq_in[2] = 1'b1;
    exp_irq(3'd2, 32'h1C0);
    tick(4);
    irq_in[2] = 1'b0;
    tick(3);
    irq_in[2] = 1'b1;
    tick(2);
    intr_ack = 1'b1;
    tick(1);
    intr_ack = 1'b0;
    rd(2'd1, "t5_pend_set_wins", 32'h4);
    irq_in[2] = 1'b0;
    wr(2'd3, 32'h0);
    pulse_eoi();
    tick(2);
    chk("t5_gie_off", 1, 32'h0);
    sample();
    wr(2'd1, 32'h4);
    rd(2'd1, "t5_w1c", 32'h0);

    // async reset during REQ
    wr(2'd3, 32'h1);
    irq_in[2] = 1'b1;
    exp_irq(3'd2, 32'h1C0);
    tick(4);
    irq_in[0] = 1'b1;
    tick(3);
    rd(2'd1, "t6_pend_pre", 32'h5);
    chk("t6_intr_pre", 1, 32'h1);
    sample();
    @(posedge clk);
    #2;
    reset = 1'b0;
    irq_in = '0;
    chk("t6_intr_async", 1, 32'h0);
    sample();
    tick(2);
    reset = 1'b1;
    tick(2);
    rd(2'd0, "t6_enable", 32'h0);
    rd(2'd1, "t6_pending", 32'h0);
    rd(2'd2, "t6_status", 32'h0);
    rd(2'd3, "t6_gie", 32'h0);
    chk("t6_intr", 1, 32'h0);
    sample();
    tick(2);

    if (irq_q.size() != 0) begin
      mismatched += irq_q.size();
      $display("FAIL missing_intr: got 0 events want %0d more", irq_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
